lsu_ctrl: RTL and testbench
===========================

LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 The block SHALL have parameter MEM_BYTES, default 4096, giving the data-memory size in bytes used for range checking.
REQ-002 The block SHALL have one clock and an asynchronous active-low reset.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rstN  input  1  asynchronous active-low reset.
REQ-005 reqValid  input  1  the pipeline presents a load/store request.
REQ-006 reqReady  output  1  the block accepts a request this cycle.
REQ-007 reqWrite  input  1  1 = store, 0 = load.
REQ-008 reqSize  input  3  access code: 000 byte, 001 half, 010 word, 100 signed byte, 101 signed half.
REQ-009 reqAddr  input  32  byte address.
REQ-010 reqWData  input  32  store data, with the byte/half in the low bits.
REQ-011 respValid  output  1  a response is available.
REQ-012 respReady  input  1  the pipeline consumes the response.
REQ-013 respData  output  32  load result; 0 for stores and errors.
REQ-014 respErr  output  1  the request was rejected.
REQ-015 errCnt  output  16  saturating count of rejected requests.
REQ-016 memAddr  output  32  data-memory address.
REQ-017 memWData  output  32  data-memory write data.
REQ-018 memSize  output  3  data-memory access code, same encoding as reqSize.
REQ-019 memWEn  output  1  data-memory write enable; the memory writes on the clk rising edge.
REQ-020 memRData  input  32  data-memory read data; combinational from memAddr/memSize and already zero/sign extended.

Function
REQ-021 The FSM SHALL have three states, IDLE, ACCESS and RESP, with reqReady=1 only in IDLE.
REQ-022 In IDLE, when reqValid&&reqReady, the block SHALL latch reqWrite/reqSize/reqAddr/reqWData and evaluate the error checks in the same cycle.
REQ-023 The request SHALL be an error if: the size code is 011, 110 or 111; or it is a store with code 100/101; or it is a half access with addr[0]!=0; or it is a word access with addr[1:0]!=0; or {1'b0,addr[30:0]}+nbytes > MEM_BYTES, where nbytes is 1, 2 or 4 and the sum is computed at 33 bits with no wrap.
REQ-024 An error request SHALL go IDLE->RESP with respErr=1 and respData=0, and memWEn SHALL never assert for it.
REQ-025 A legal request SHALL go IDLE->ACCESS; ACCESS SHALL last exactly one cycle and then go ->RESP.
REQ-026 In ACCESS the block SHALL drive memAddr, memSize and memWData from the latched values, and memWEn=latched reqWrite.
REQ-027 memWEn SHALL be 1 only in ACCESS for a legal store, giving exactly one write per store.
REQ-028 For a legal load, memRData SHALL be registered into respData at the end of ACCESS; for a store, respData SHALL be 0.
REQ-029 Outside ACCESS, memWEn SHALL be 0, and memAddr/memSize/memWData SHALL hold their last latched values.
REQ-030 In RESP, respValid=1 and respData/respErr SHALL be held stable until respReady=1; on that cycle the FSM SHALL go ->IDLE.
REQ-031 A new request SHALL NOT be accepted in the cycle the response is consumed.
REQ-032 Latency: request accepted at edge N, respValid=1 from edge N+2 for a legal request and from edge N+1 for an error.
REQ-033 errCnt SHALL increment by 1 on each IDLE->RESP error transition and saturate at 16'hFFFF.
REQ-034 reqValid while reqReady=0 SHALL be ignored, and the pipeline holds the request.

Reset
REQ-035 When rstN=0, the block SHALL asynchronously force state=IDLE, respValid=0, respErr=0, respData=0, errCnt=0, memWEn=0, memAddr=0, memWData=0, memSize=000.
REQ-036 Reset asserted in ACCESS SHALL drop memWEn immediately, discard the request and produce no response.
REQ-037 After rstN deasserts, reqReady SHALL be 1 in the first cycle.

Verification
REQ-038 Store word 0xCAFEBABE to 0x100, then load word from 0x100 -> exactly one memWEn pulse; load response 0xCAFEBABE, respErr=0, 2 cycles after acceptance.
REQ-039 Memory byte at 0x20=0x80; load code 100 then 000 from 0x20 -> respData 0xFFFFFF80, then 0x00000080.
REQ-040 Load word from 0x102, store half to 0x001, store with code 100, and load word from 0xFFE (MEM_BYTES=4096) -> each gives respErr=1, respData=0, no memWEn pulse, respValid 1 cycle after acceptance; errCnt=4.
REQ-041 Hold respReady=0 for 5 cycles in RESP -> respValid, respData and respErr are stable, reqReady=0, and a new reqValid is ignored.
REQ-042 Assert rstN=0 mid-cycle during a store ACCESS -> memWEn falls without waiting for clk, the memory is unchanged, and no response follows.
REQ-043 Force errCnt to 0xFFFF via 65535 errors, then one more error -> errCnt stays 0xFFFF.

Source files
------------

// File: rtl/lsu_ctrl_if.sv
// rtl/lsu_ctrl_if.sv - request/response/data-memory signal bundle for lsu_ctrl
//
// Purpose: groups the pipeline request/response handshake and the data-memory
// port of lsu_ctrl. clk and rstN stay plain ports on the module.
//   slave  : lsu_ctrl side (takes requests, drives responses and memory port)
//   master : pipeline + data-memory side
interface lsu_ctrl_if;
    logic        reqValid;
    logic        reqReady;
    logic        reqWrite;
    logic [2:0]  reqSize;
    logic [31:0] reqAddr;
    logic [31:0] reqWData;
    logic        respValid;
    logic        respReady;
    logic [31:0] respData;
    logic        respErr;
    logic [15:0] errCnt;
    logic [31:0] memAddr;
    logic [31:0] memWData;
    logic [2:0]  memSize;
    logic        memWEn;
    logic [31:0] memRData;

    modport slave (
        input  reqValid, reqWrite, reqSize, reqAddr, reqWData, respReady, memRData,
        output reqReady, respValid, respData, respErr, errCnt,
        output memAddr, memWData, memSize, memWEn
    );

    modport master (
        output reqValid, reqWrite, reqSize, reqAddr, reqWData, respReady, memRData,
        input  reqReady, respValid, respData, respErr, errCnt,
        input  memAddr, memWData, memSize, memWEn
    );
endinterface

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - load/store unit controller with range/alignment checking
//
// Purpose: accepts one load/store at a time from the pipeline, rejects illegal
// requests, performs a single-cycle data-memory access for legal ones and
// returns a held response.
// Ports:
//   clk   - clock, all state updates on rising edge
//   rstN  - asynchronous active-low reset
//   bus   - lsu_ctrl_if.slave: req* handshake in, resp*/errCnt out,
//           mem* data-memory port (memRData combinational, already extended)
// Parameter:
//   MEM_BYTES - data-memory size in bytes for range checking
module lsu_ctrl #(
    parameter int unsigned MEM_BYTES = 4096
) (
    input  logic        clk,
    input  logic        rstN,
    lsu_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic        write_q;
    logic [2:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] resp_data_q;
    logic        resp_err_q;
    logic [15:0] err_cnt_q;

    logic        accept;
    logic        req_err;
    logic        size_ok;
    logic        align_ok;
    logic        range_err;
    logic [2:0]  nbytes;
    logic [32:0] end_addr;

    // Request legality; evaluated combinationally on the request inputs so the
    // decision is made in the acceptance cycle.
    always_comb begin
        size_ok  = 1'b0;
        nbytes   = 3'd0;
        align_ok = 1'b1;
        case (bus.reqSize)
            3'b000, 3'b100: begin
                size_ok = 1'b1;
                nbytes  = 3'd1;
            end
            3'b001, 3'b101: begin
                size_ok  = 1'b1;
                nbytes   = 3'd2;
                align_ok = (bus.reqAddr[0] == 1'b0);
            end
            3'b010: begin
                size_ok  = 1'b1;
                nbytes   = 3'd4;
                align_ok = (bus.reqAddr[1:0] == 2'b00);
            end
            default: begin
                size_ok = 1'b0;
                nbytes  = 3'd0;
            end
        endcase
        // Address bit 31 is ignored; 33-bit sum so the end address cannot wrap.
        end_addr  = {2'b00, bus.reqAddr[30:0]} + {30'd0, nbytes};
        range_err = (end_addr > 33'(MEM_BYTES));
        // Sign-extending codes make no sense for stores.
        req_err   = !size_ok || (bus.reqWrite && bus.reqSize[2]) || !align_ok || range_err;
    end

    assign accept = (state_q == IDLE) && bus.reqValid;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = req_err ? RESP : ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    if (bus.respReady) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            write_q     <= 1'b0;
            size_q      <= 3'b000;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            resp_data_q <= 32'd0;
            resp_err_q  <= 1'b0;
            err_cnt_q   <= 16'd0;
        end else begin
            if (accept) begin
                write_q     <= bus.reqWrite;
                size_q      <= bus.reqSize;
                addr_q      <= bus.reqAddr;
                wdata_q     <= bus.reqWData;
                resp_data_q <= 32'd0;
                resp_err_q  <= req_err;
                if (req_err && (err_cnt_q != 16'hFFFF)) begin
                    err_cnt_q <= err_cnt_q + 16'd1;
                end
            end
            if (state_q == ACCESS) begin
                resp_data_q <= write_q ? 32'd0 : bus.memRData;
            end
        end
    end

    assign bus.reqReady  = (state_q == IDLE);
    assign bus.respValid = (state_q == RESP);
    assign bus.respData  = resp_data_q;
    assign bus.respErr   = resp_err_q;
    assign bus.errCnt    = err_cnt_q;

    // The memory port shows the latched request at all times; only the write
    // enable is gated by state, so reset drops it without waiting for clk.
    assign bus.memAddr   = addr_q;
    assign bus.memWData  = wdata_q;
    assign bus.memSize   = size_q;
    assign bus.memWEn    = (state_q == ACCESS) && write_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - self-checking bench for lsu_ctrl
module tb_lsu_ctrl;

    logic clk;
    logic rstN;
    lsu_ctrl_if bus();

    lsu_ctrl #(.MEM_BYTES(4096)) dut (
        .clk  (clk),
        .rstN (rstN),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int wr_cnt = 0;
    logic mem_clear;

    logic [7:0] mem [0:4095];

    // Byte-addressed little-endian memory model using the low 12 address bits.
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 8'h00;
        end else if (bus.memWEn) begin
            wr_cnt = wr_cnt + 1;
            case (bus.memSize)
                3'b000: mem[bus.memAddr[11:0]] <= bus.memWData[7:0];
                3'b001: begin
                    mem[bus.memAddr[11:0]]          <= bus.memWData[7:0];
                    mem[bus.memAddr[11:0] + 12'd1]  <= bus.memWData[15:8];
                end
                default: begin
                    mem[bus.memAddr[11:0]]          <= bus.memWData[7:0];
                    mem[bus.memAddr[11:0] + 12'd1]  <= bus.memWData[15:8];
                    mem[bus.memAddr[11:0] + 12'd2]  <= bus.memWData[23:16];
                    mem[bus.memAddr[11:0] + 12'd3]  <= bus.memWData[31:24];
                end
            endcase
        end
    end

    logic [11:0] ra;
    always_comb begin
        ra = bus.memAddr[11:0];
        case (bus.memSize)
            3'b000:  bus.memRData = {24'd0, mem[ra]};
            3'b100:  bus.memRData = {{24{mem[ra][7]}}, mem[ra]};
            3'b001:  bus.memRData = {16'd0, mem[ra + 12'd1], mem[ra]};
            3'b101:  bus.memRData = {{16{mem[ra + 12'd1][7]}}, mem[ra + 12'd1], mem[ra]};
            default: bus.memRData = {mem[ra + 12'd3], mem[ra + 12'd2], mem[ra + 12'd1], mem[ra]};
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one request, wait for the response, return data/err and the number
    // of edges from acceptance to respValid, then consume the response.
    task automatic run_req(input logic w, input logic [2:0] sz, input logic [31:0] a,
                           input logic [31:0] d, output logic [31:0] rd,
                           output logic re, output int lat);
        int guard;
        @(negedge clk);
        bus.reqValid = 1'b1;
        bus.reqWrite = w;
        bus.reqSize  = sz;
        bus.reqAddr  = a;
        bus.reqWData = d;
        guard = 0;
        while (!bus.reqReady && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        @(negedge clk);
        bus.reqValid = 1'b0;
        lat = 1;
        while (!bus.respValid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        rd = bus.respData;
        re = bus.respErr;
        bus.respReady = 1'b1;
        @(negedge clk);
        bus.respReady = 1'b0;
    endtask

    typedef struct {
        logic        w;
        logic [2:0]  sz;
        logic [31:0] a;
        logic [31:0] d;
        logic        e_err;
        logic [31:0] e_data;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic w, input logic [2:0] sz, input logic [31:0] a,
                                input logic [31:0] d, input logic e_err, input logic [31:0] e_data);
        vec_t v;
        v.w = w; v.sz = sz; v.a = a; v.d = d; v.e_err = e_err; v.e_data = e_data;
        return v;
    endfunction

    initial begin
        logic [31:0] rd;
        logic        re;
        int          lat;
        int          w0;
        int          exp_cnt;
        string       nm;

        vecs.push_back(mk(1, 3'b010, 32'h100, 32'hCAFEBABE, 0, 32'h0));
        vecs.push_back(mk(0, 3'b010, 32'h100, 32'h0,        0, 32'hCAFEBABE));
        vecs.push_back(mk(1, 3'b000, 32'h020, 32'h12345680, 0, 32'h0));
        vecs.push_back(mk(0, 3'b100, 32'h020, 32'h0,        0, 32'hFFFFFF80));
        vecs.push_back(mk(0, 3'b000, 32'h020, 32'h0,        0, 32'h00000080));
        vecs.push_back(mk(1, 3'b001, 32'h040, 32'h1234ABCD, 0, 32'h0));
        vecs.push_back(mk(0, 3'b101, 32'h040, 32'h0,        0, 32'hFFFFABCD));
        vecs.push_back(mk(0, 3'b001, 32'h040, 32'h0,        0, 32'h0000ABCD));
        vecs.push_back(mk(0, 3'b010, 32'h102, 32'h0,        1, 32'h0));
        vecs.push_back(mk(1, 3'b001, 32'h001, 32'h1111,     1, 32'h0));
        vecs.push_back(mk(1, 3'b100, 32'h010, 32'h22,       1, 32'h0));
        vecs.push_back(mk(0, 3'b010, 32'hFFE, 32'h0,        1, 32'h0));
        vecs.push_back(mk(0, 3'b010, 32'hFFC, 32'h0,        0, 32'h0));
        vecs.push_back(mk(0, 3'b000, 32'hFFF, 32'h0,        0, 32'h0));
        vecs.push_back(mk(0, 3'b000, 32'h1000, 32'h0,       1, 32'h0));
        vecs.push_back(mk(0, 3'b011, 32'h000, 32'h0,        1, 32'h0));
        vecs.push_back(mk(0, 3'b110, 32'h000, 32'h0,        1, 32'h0));
        vecs.push_back(mk(0, 3'b111, 32'h000, 32'h0,        1, 32'h0));
        vecs.push_back(mk(0, 3'b010, 32'h80000100, 32'h0,   0, 32'hCAFEBABE));

        bus.reqValid  = 1'b0;
        bus.reqWrite  = 1'b0;
        bus.reqSize   = 3'b000;
        bus.reqAddr   = 32'd0;
        bus.reqWData  = 32'd0;
        bus.respReady = 1'b0;
        mem_clear     = 1'b1;
        rstN          = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_respValid", {31'd0, bus.respValid}, 32'd0);
        chk("rst_respErr",   {31'd0, bus.respErr},   32'd0);
        chk("rst_respData",  bus.respData,           32'd0);
        chk("rst_errCnt",    {16'd0, bus.errCnt},    32'd0);
        chk("rst_memWEn",    {31'd0, bus.memWEn},    32'd0);
        chk("rst_memAddr",   bus.memAddr,            32'd0);
        chk("rst_memWData",  bus.memWData,           32'd0);
        chk("rst_memSize",   {29'd0, bus.memSize},   32'd0);

        rstN      = 1'b1;
        mem_clear = 1'b0;
        @(negedge clk);
        chk("post_rst_reqReady", {31'd0, bus.reqReady}, 32'd1);

        exp_cnt = 0;
        foreach (vecs[i]) begin
            w0 = wr_cnt;
            run_req(vecs[i].w, vecs[i].sz, vecs[i].a, vecs[i].d, rd, re, lat);
            if (vecs[i].e_err) exp_cnt++;
            nm = $sformatf("vec%0d", i);
            chk({nm, "_err"},  {31'd0, re}, {31'd0, vecs[i].e_err});
            chk({nm, "_data"}, rd, vecs[i].e_data);
            chk({nm, "_lat"},  lat, vecs[i].e_err ? 1 : 2);
            chk({nm, "_wr"},   wr_cnt - w0, (vecs[i].w && !vecs[i].e_err) ? 1 : 0);
            chk({nm, "_cnt"},  {16'd0, bus.errCnt}, exp_cnt);
        end

        // Response held with respReady low; a competing request is ignored.
        w0 = wr_cnt;
        @(negedge clk);
        bus.reqValid = 1'b1; bus.reqWrite = 1'b0; bus.reqSize = 3'b010;
        bus.reqAddr  = 32'h100; bus.reqWData = 32'h0;
        @(posedge clk);
        @(negedge clk);
        bus.reqWrite = 1'b1; bus.reqAddr = 32'h300; bus.reqWData = 32'hDEADBEEF;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("hold%0d_valid", k), {31'd0, bus.respValid}, 32'd1);
            chk($sformatf("hold%0d_data", k),  bus.respData, 32'hCAFEBABE);
            chk($sformatf("hold%0d_err", k),   {31'd0, bus.respErr}, 32'd0);
            chk($sformatf("hold%0d_ready", k), {31'd0, bus.reqReady}, 32'd0);
            chk($sformatf("hold%0d_addr", k),  bus.memAddr, 32'h100);
            @(negedge clk);
        end
        bus.reqValid  = 1'b0;
        bus.respReady = 1'b1;
        @(negedge clk);
        bus.respReady = 1'b0;
        chk("hold_idle_valid", {31'd0, bus.respValid}, 32'd0);
        chk("hold_no_write", wr_cnt - w0, 32'd0);

        // Reset in the middle of a store ACCESS cycle.
        w0 = wr_cnt;
        bus.reqValid = 1'b1; bus.reqWrite = 1'b1; bus.reqSize = 3'b010;
        bus.reqAddr  = 32'h200; bus.reqWData = 32'h55AA55AA;
        @(posedge clk);
        @(negedge clk);
        bus.reqValid = 1'b0;
        chk("acc_memWEn", {31'd0, bus.memWEn}, 32'd1);
        #2;
        rstN = 1'b0;
        #1;
        chk("rst_async_memWEn", {31'd0, bus.memWEn}, 32'd0);
        @(negedge clk);
        rstN = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rst_no_resp", {31'd0, bus.respValid}, 32'd0);
        end
        chk("rst_no_write", wr_cnt - w0, 32'd0);
        chk("rst_mem_unchanged", {mem[12'h203], mem[12'h202], mem[12'h201], mem[12'h200]}, 32'd0);
        chk("rst_errCnt_clr", {16'd0, bus.errCnt}, 32'd0);

        // Saturation: preload the counter near the top, then keep erroring.
        @(negedge clk);
        force dut.err_cnt_q = 16'hFFFD;
        #1;
        release dut.err_cnt_q;
        run_req(1'b1, 3'b100, 32'h0, 32'h0, rd, re, lat);
        chk("sat_cnt1", {16'd0, bus.errCnt}, 32'h0000FFFE);
        run_req(1'b1, 3'b100, 32'h0, 32'h0, rd, re, lat);
        chk("sat_cnt2", {16'd0, bus.errCnt}, 32'h0000FFFF);
        run_req(1'b1, 3'b100, 32'h0, 32'h0, rd, re, lat);
        chk("sat_cnt3", {16'd0, bus.errCnt}, 32'h0000FFFF);
        chk("sat_err", {31'd0, re}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
